// File: rtl/reg_feed_seq.sv
// Command-driven sequencer that feeds a downstream register stage (clear, load, serial shift).
// Optional macro REG_FEED_PARITY_EN appends an even-parity bit to every SHIFT command.
module reg_feed_seq #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             synch_reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_word,
  output logic             ce_out,
  output logic             sreset_n_out,
  output logic             sload_out,
  output logic             data_out,
  output logic             d_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

`ifdef REG_FEED_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  localparam logic [4:0] BIT_LAST  = 5'(NBITS - 1);
  localparam logic [4:0] DATA_LAST = 5'(WIDTH - 1);
  localparam logic [4:0] DIV_LAST  = 5'(DIV - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [4:0]       div_cnt_q, div_cnt_d;
  logic             ready_q, ready_d;
  logic             ce_q, ce_d;
  logic             srst_n_q, srst_n_d;
  logic             sload_q, sload_d;
  logic             data_q, data_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef REG_FEED_PARITY_EN
  logic             par_q, par_d;
`endif

  logic accept;

  // Ready is a state decode; reset masks it so a coincident valid is never taken.
  assign cmd_ready = ready_q & ~synch_reset;
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    ce_d      = 1'b0;
    srst_n_d  = 1'b1;
    sload_d   = 1'b0;
    data_d    = data_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
`ifdef REG_FEED_PARITY_EN
    par_d     = par_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_NOP: begin
              state_d = DONE;
              done_d  = 1'b1;
            end
            OP_CLEAR: begin
              state_d  = PULSE;
              ce_d     = 1'b1;
              srst_n_d = 1'b0;
            end
            OP_LOAD: begin
              state_d = PULSE;
              ce_d    = 1'b1;
              sload_d = 1'b1;
              data_d  = cmd_word[0];
            end
            OP_SHIFT: begin
              state_d   = SHIFT;
              ce_d      = 1'b1;
              sh_d      = cmd_word;
              dout_d    = cmd_word[WIDTH-1];
              bit_cnt_d = '0;
              div_cnt_d = '0;
`ifdef REG_FEED_PARITY_EN
              par_d     = ^cmd_word;
`endif
            end
            default: state_d = IDLE;
          endcase
        end
      end
      PULSE: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = DONE;
            done_d    = 1'b1;
            bit_cnt_d = '0;
          end else begin
            // Advance to the next bit period: the MSB of the shifted word, or parity after the LSB.
            bit_cnt_d = bit_cnt_q + 5'd1;
            ce_d      = 1'b1;
            sh_d      = sh_q << 1;
`ifdef REG_FEED_PARITY_EN
            dout_d    = (bit_cnt_q == DATA_LAST) ? par_q : sh_q[WIDTH-2];
`else
            dout_d    = sh_q[WIDTH-2];
`endif
          end
        end else begin
          div_cnt_d = div_cnt_q + 5'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

`ifndef REG_FEED_PARITY_EN
  logic unused_data_last;
  assign unused_data_last = ^DATA_LAST;
`endif

  always_ff @(posedge clk) begin
    if (synch_reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      ready_q   <= 1'b1;
      ce_q      <= 1'b0;
      srst_n_q  <= 1'b1;
      sload_q   <= 1'b0;
      data_q    <= 1'b0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef REG_FEED_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      ready_q   <= ready_d;
      ce_q      <= ce_d;
      srst_n_q  <= srst_n_d;
      sload_q   <= sload_d;
      data_q    <= data_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef REG_FEED_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign ce_out       = ce_q;
  assign sreset_n_out = srst_n_q;
  assign sload_out    = sload_q;
  assign data_out     = data_q;
  assign d_out        = dout_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_reg_feed_seq.sv
// Directed bench for reg_feed_seq: one instance with DIV=1, one with DIV=3.
module tb_reg_feed_seq;

`ifdef REG_FEED_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       synch_reset;
  logic       v1, v3;
  logic [1:0] op;
  logic [7:0] word;
  logic r1, ce1, srn1, sl1, dat1, d1, b1, dn1;
  logic r3, ce3, srn3, sl3, dat3, d3, b3, dn3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_feed_seq #(.WIDTH(8), .DIV(1)) u_dut1 (
    .clk(clk), .synch_reset(synch_reset), .cmd_valid(v1), .cmd_ready(r1),
    .cmd_op(op), .cmd_word(word), .ce_out(ce1), .sreset_n_out(srn1),
    .sload_out(sl1), .data_out(dat1), .d_out(d1), .busy(b1), .done(dn1)
  );

  reg_feed_seq #(.WIDTH(8), .DIV(3)) u_dut3 (
    .clk(clk), .synch_reset(synch_reset), .cmd_valid(v3), .cmd_ready(r3),
    .cmd_op(op), .cmd_word(word), .ce_out(ce3), .sreset_n_out(srn3),
    .sload_out(sl3), .data_out(dat3), .d_out(d3), .busy(b3), .done(dn3)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] w, input int k);
    if (k < 8) return w[7-k];
    return ^w;
  endfunction

  initial begin
    int   n;
    logic last;
    synch_reset = 1'b1;
    v1 = 1'b1; v3 = 1'b1; op = 2'b11; word = 8'hFF;

    // Reset with a coincident valid: nothing may be accepted.
    tick();
    chk("rst_rdy_low", r1, 0);
    chk("rst_busy", b1, 0);
    tick();
    synch_reset = 1'b0; v1 = 1'b0; v3 = 1'b0;
    #1;
    chk("rel_rdy", r1, 1);
    chk("rel_ce", ce1, 0);
    chk("rel_srn", srn1, 1);
    chk("rel_sload", sl1, 0);
    chk("rel_data", dat1, 0);
    chk("rel_dout", d1, 0);
    chk("rel_done", dn1, 0);
    chk("rel_busy3", b3, 0);
    tick();
    chk("idle_busy", b1, 0);

    // SHIFT 0xA5, DIV=1.
    v1 = 1'b1; op = 2'b11; word = 8'hA5;
    tick();
    v1 = 1'b0;
    for (int k = 0; k < NB; k++) begin
      chk("a5_ce", ce1, 1);
      chk("a5_dout", d1, exp_bit(8'hA5, k));
      chk("a5_rdy", r1, 0);
      tick();
    end
    chk("a5_done", dn1, 1);
    chk("a5_done_ce", ce1, 0);
    chk("a5_done_busy", b1, 1);
    tick();
    chk("a5_idle_rdy", r1, 1);
    chk("a5_idle_done", dn1, 0);

    // SHIFT 0x81, DIV=3.
    v3 = 1'b1; op = 2'b11; word = 8'h81;
    tick();
    v3 = 1'b0;
    for (int c = 0; c < NB*3; c++) begin
      chk("d3_ce", ce3, ((c % 3) == 0) ? 1 : 0);
      chk("d3_dout", d3, exp_bit(8'h81, c / 3));
      chk("d3_done_early", dn3, 0);
      tick();
    end
    chk("d3_done", dn3, 1);
    chk("d3_ce_done", ce3, 0);
    tick();
    chk("d3_rdy", r3, 1);

    // LOAD bit0=1.
    v1 = 1'b1; op = 2'b10; word = 8'h01;
    tick();
    v1 = 1'b0;
    chk("ld_ce", ce1, 1);
    chk("ld_sload", sl1, 1);
    chk("ld_data", dat1, 1);
    chk("ld_srn", srn1, 1);
    tick();
    chk("ld_done", dn1, 1);
    chk("ld_ce_off", ce1, 0);
    chk("ld_sload_off", sl1, 0);
    chk("ld_data_hold", dat1, 1);
    tick();

    // CLEAR.
    v1 = 1'b1; op = 2'b01; word = 8'h00;
    tick();
    v1 = 1'b0;
    chk("clr_srn", srn1, 0);
    chk("clr_ce", ce1, 1);
    chk("clr_sload", sl1, 0);
    tick();
    chk("clr_srn_off", srn1, 1);
    chk("clr_done", dn1, 1);
    chk("clr_data_hold", dat1, 1);
    tick();

    // Back-to-back: NOP then SHIFT 0x07 with valid held high.
    v1 = 1'b1; op = 2'b00; word = 8'h07;
    chk("b2b_rdy0", r1, 1);
    tick();
    op = 2'b11;
    chk("b2b_nop_done", dn1, 1);
    chk("b2b_nop_rdy", r1, 0);
    chk("b2b_nop_busy", b1, 1);
    tick();
    chk("b2b_idle_rdy", r1, 1);
    chk("b2b_idle_busy", b1, 0);
    tick();
    v1 = 1'b0;
    chk("b2b_sh_ce", ce1, 1);
    chk("b2b_sh_d0", d1, 0);
    n = 0;
    last = d1;
    while (!dn1 && n < 40) begin
      chk("b2b_rdy_busy", r1, 0);
      last = d1;
      tick();
      n++;
    end
    chk("b2b_done", dn1, 1);
    chk("b2b_len", n, NB);
    chk("b2b_last_bit", last, 1);
    tick();

    // Reset in the middle of a SHIFT.
    v1 = 1'b1; op = 2'b11; word = 8'hA5;
    tick();
    v1 = 1'b0;
    tick(); tick(); tick();
    chk("mr_ce_s3", ce1, 1);
    chk("mr_d_s3", d1, 0);
    synch_reset = 1'b1;
    tick();
    chk("mr_ce", ce1, 0);
    chk("mr_busy", b1, 0);
    chk("mr_done", dn1, 0);
    chk("mr_rdy_in_rst", r1, 0);
    synch_reset = 1'b0;
    #1;
    chk("mr_rdy_rel", r1, 1);
    tick();
    chk("mr_no_done", dn1, 0);
    chk("mr_rdy_after", r1, 1);
    chk("mr_ce_after", ce1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
